// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU page-table write path: widths, command
// encodings, the command payload and the page-table entry formatter.
package mmu_pkg;

  localparam int unsigned PROC_W      = 7;
  localparam int unsigned VPAGE_W     = 5;
  localparam int unsigned PPAGE_W     = 7;
  localparam int unsigned ADDR_W      = PROC_W + VPAGE_W;
  localparam int unsigned ENTRY_W     = PPAGE_W + 1;
  localparam int unsigned ENTRY_VALID = 7;
  localparam int unsigned PT_DEPTH    = 4096;

  typedef enum logic [1:0] {
    OP_LINEAR = 2'b00,
    OP_MAP    = 2'b01,
    OP_UNMAP  = 2'b10,
    OP_CLEAR  = 2'b11
  } mmu_op_e;

  typedef struct packed {
    mmu_op_e              op;
    logic [PROC_W-1:0]    proc;
    logic [VPAGE_W-1:0]   vpage;
    logic [PPAGE_W-1:0]   ppage;
  } mmu_cmd_t;

  // Invalid entries are all-zero so a stale physical page never leaks out.
  function automatic logic [ENTRY_W-1:0] mmu_pte_fmt(input logic valid,
                                                     input logic [PPAGE_W-1:0] ppage);
    logic [ENTRY_W-1:0] e;
    e = '0;
    if (valid) begin
      e[PPAGE_W-1:0]  = ppage;
      e[ENTRY_VALID]  = 1'b1;
    end
    return e;
  endfunction

endpackage

// File: rtl/mmu_table_ctrl.sv
// Page-table write sequencer: turns map/unmap/clear/linear-fill commands into
// single-cycle table writes, yielding the port to live translation lookups.
module mmu_table_ctrl
  import mmu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [PROC_W-1:0]    cmd_proc,
  input  logic [VPAGE_W-1:0]   cmd_vpage,
  input  logic [PPAGE_W-1:0]   cmd_ppage,
  input  logic                 lookup_act,
  output logic                 pt_we,
  output logic [ADDR_W-1:0]    pt_waddr,
  output logic [ENTRY_W-1:0]   pt_wdata,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SINGLE = 2'b01,
    ST_BULK   = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  localparam logic [VPAGE_W-1:0] IDX_LAST = '1;

  state_e               state;
  mmu_cmd_t             cmd_q;
  logic [VPAGE_W-1:0]   idx;

  logic                 active_c;
  logic                 bulk_c;
  logic                 valid_c;
  logic [VPAGE_W-1:0]   page_c;
  logic [PPAGE_W-1:0]   ppage_c;
  mmu_op_e              op_in_c;

  // Write address/data come only from latched state so they hold across stalls.
  always_comb begin
    active_c = (state == ST_SINGLE) || (state == ST_BULK);
    bulk_c   = (state == ST_BULK);
    page_c   = bulk_c ? idx : cmd_q.vpage;
    ppage_c  = bulk_c ? PPAGE_W'(cmd_q.ppage + PPAGE_W'(idx)) : cmd_q.ppage;
    valid_c  = active_c && ((cmd_q.op == OP_MAP) || (cmd_q.op == OP_LINEAR));
    op_in_c  = mmu_op_e'(cmd_op);
  end

  assign pt_we    = active_c && !lookup_act;
  assign pt_waddr = {cmd_q.proc, page_c};
  assign pt_wdata = mmu_pte_fmt(valid_c, ppage_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q.op    <= op_in_c;
            cmd_q.proc  <= cmd_proc;
            cmd_q.vpage <= cmd_vpage;
            cmd_q.ppage <= cmd_ppage;
            idx         <= '0;
            busy        <= 1'b1;
            cmd_ready   <= 1'b0;
            state       <= (op_in_c inside {OP_MAP, OP_UNMAP}) ? ST_SINGLE : ST_BULK;
          end
        end
        ST_SINGLE: begin
          if (pt_we) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_BULK: begin
          if (pt_we) begin
            if (idx == IDX_LAST) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + VPAGE_W'(1);
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_table_ctrl.sv
// Bench for mmu_table_ctrl: directed and random commands checked against a
// table-level model of what each command must leave in the page table.
module tb_mmu_table_ctrl;
  import mmu_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_proc;
  logic [4:0]  cmd_vpage;
  logic [6:0]  cmd_ppage;
  logic        lookup_act;
  logic        pt_we;
  logic [11:0] pt_waddr;
  logic [7:0]  pt_wdata;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0] tbl     [4096];
  logic [7:0] exp_tbl [4096];
  logic       init_tbl;
  int         wr_cnt;
  int         exp_wr;

  mmu_table_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_proc   (cmd_proc),
    .cmd_vpage  (cmd_vpage),
    .cmd_ppage  (cmd_ppage),
    .lookup_act (lookup_act),
    .pt_we      (pt_we),
    .pt_waddr   (pt_waddr),
    .pt_wdata   (pt_wdata),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] seed(input int i);
    return 8'((i * 37 + 11) ^ (i >> 4));
  endfunction

  // Behavioural page-table memory written through the DUT's write port.
  always @(posedge clk) begin
    if (init_tbl) begin
      for (int i = 0; i < 4096; i++) tbl[i] <= seed(i);
      wr_cnt <= 0;
    end else if (pt_we) begin
      tbl[pt_waddr] <= pt_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_table(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 4096; i++) if (tbl[i] !== exp_tbl[i]) bad++;
    chk(tag, 32'(bad), 32'(0));
    chk({tag, "_wrcnt"}, 32'(wr_cnt), 32'(exp_wr));
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [6:0] p, input logic [4:0] v,
                         input logic [6:0] pp);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_proc  = p;
    cmd_vpage = v;
    cmd_ppage = pp;
  endtask

  task automatic issue(input logic [1:0] op, input logic [6:0] p, input logic [4:0] v,
                       input logic [6:0] pp);
    chk("ready_before_cmd", 32'(cmd_ready), 32'(1));
    set_cmd(op, p, v, pp);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Follows one accepted command from cycle N+1; the model decides each write.
  task automatic monitor(input logic [1:0] op, input logic [6:0] p, input logic [4:0] v,
                         input logic [6:0] pp, input int lk_lo, input int lk_hi,
                         input int abort_w);
    int nw, w, ea, ed;
    bit fin;
    nw  = (op == 2'b01 || op == 2'b10) ? 1 : 32;
    w   = 0;
    fin = 1'b0;
    for (int k = 1; k <= 80 && !fin; k++) begin
      lookup_act = (k >= lk_lo && k <= lk_hi);
      if (w == abort_w) begin
        rst = 1'b1;
        lookup_act = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lookup_act = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_ready", 32'(cmd_ready), 32'(1));
        chk("abort_we", 32'(pt_we), 32'(0));
        chk("abort_waddr", 32'(pt_waddr), 32'(0));
        chk("abort_wdata", 32'(pt_wdata), 32'(0));
        for (int j = 0; j < 4; j++) begin
          chk("abort_no_done", 32'(done), 32'(0));
          @(negedge clk);
        end
        fin = 1'b1;
      end else begin
        @(negedge clk);
        if (w < nw) begin
          if (nw == 1) begin
            ea = int'(p) * 32 + int'(v);
            ed = (op == 2'b01) ? 128 + int'(pp) : 0;
          end else begin
            ea = int'(p) * 32 + w;
            ed = (op == 2'b00) ? 128 + (int'(pp) + w) % 128 : 0;
          end
          chk("busy_active", 32'(busy), 32'(1));
          chk("done_early", 32'(done), 32'(0));
          chk("ready_busy", 32'(cmd_ready), 32'(0));
          chk("we", 32'(pt_we), 32'(!lookup_act));
          chk("waddr", 32'(pt_waddr), 32'(ea));
          chk("wdata", 32'(pt_wdata), 32'(ed));
          if (!lookup_act) begin
            exp_tbl[ea] = 8'(ed);
            exp_wr++;
            w++;
          end
        end else begin
          chk("done_pulse", 32'(done), 32'(1));
          chk("busy_done", 32'(busy), 32'(0));
          chk("ready_done", 32'(cmd_ready), 32'(0));
          chk("we_done", 32'(pt_we), 32'(0));
          @(posedge clk); #1;
          @(negedge clk);
          chk("done_single", 32'(done), 32'(0));
          chk("ready_after", 32'(cmd_ready), 32'(1));
          chk("busy_after", 32'(busy), 32'(0));
          fin = 1'b1;
        end
        if (!fin) begin
          @(posedge clk); #1;
        end
      end
    end
    chk("cmd_finished", 32'(fin), 32'(1));
    lookup_act = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rop;
    logic [6:0] rp, rpp;
    logic [4:0] rv;
    int         lo, hi;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_proc = '0; cmd_vpage = '0;
    cmd_ppage = '0; lookup_act = 1'b0; init_tbl = 1'b1; exp_wr = 0;
    for (int i = 0; i < 4096; i++) exp_tbl[i] = seed(i);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    init_tbl = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_we", 32'(pt_we), 32'(0));
    chk("rst_waddr", 32'(pt_waddr), 32'(0));
    chk("rst_wdata", 32'(pt_wdata), 32'(0));
    chk("rst_ready", 32'(cmd_ready), 32'(1));

    // Command arriving together with reset is dropped.
    set_cmd(2'b01, 7'd4, 5'd4, 7'h44);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cmd_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("rstcmd_busy", 32'(busy), 32'(0));
      chk("rstcmd_we", 32'(pt_we), 32'(0));
    end
    chk("rstcmd_wrcnt", 32'(wr_cnt), 32'(exp_wr));

    issue(2'b01, 7'd3, 5'd5, 7'h2A);
    monitor(2'b01, 7'd3, 5'd5, 7'h2A, 0, -1, -1);
    chk("map_entry_065", 32'(tbl[12'h065]), 32'(8'hAA));

    issue(2'b11, 7'h7F, 5'd0, 7'd0);
    monitor(2'b11, 7'h7F, 5'd0, 7'd0, 0, -1, -1);

    issue(2'b00, 7'd1, 5'd0, 7'h70);
    monitor(2'b00, 7'd1, 5'd0, 7'h70, 0, -1, -1);
    chk("linear_wrap_030", 32'(tbl[12'h030]), 32'(8'h80));
    chk("linear_last_03f", 32'(tbl[12'h03F]), 32'(8'h8F));

    issue(2'b01, 7'd9, 5'd17, 7'h11);
    monitor(2'b01, 7'd9, 5'd17, 7'h11, 1, 3, -1);

    issue(2'b00, 7'h40, 5'd0, 7'h05);
    monitor(2'b00, 7'h40, 5'd0, 7'h05, 0, -1, 10);
    cmp_table("table_directed");

    // Held cmd_valid with a new payload must wait for IDLE, then be taken once.
    set_cmd(2'b10, 7'd3, 5'd5, 7'h00);
    @(posedge clk); #1;
    set_cmd(2'b01, 7'h22, 5'd3, 7'h55);
    monitor(2'b10, 7'd3, 5'd5, 7'h00, 0, -1, -1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    monitor(2'b01, 7'h22, 5'd3, 7'h55, 0, -1, -1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("hold_idle_busy", 32'(busy), 32'(0));
    end
    cmp_table("table_hold");

    for (int n = 0; n < 16; n++) begin
      rop = 2'($urandom_range(0, 3));
      rp  = 7'($urandom);
      rv  = 5'($urandom);
      rpp = 7'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        lo = 0; hi = -1;
      end else begin
        lo = int'($urandom_range(1, 8));
        hi = lo + int'($urandom_range(0, 4));
      end
      issue(rop, rp, rv, rpp);
      monitor(rop, rp, rv, rpp, lo, hi, -1);
    end
    cmp_table("table_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
